// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch and decode stages: opcodes, the NOP word,
// the SIIC vector and the fetch-stage state encoding.
package isa_pkg;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;
    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;

    localparam logic [15:0] NOP_INSTR    = {OP_NOP, 11'b0};
    localparam logic [15:0] SIIC_VEC_DEF = 16'h0002;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        HOLD   = 2'b01,
        HALTED = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC priority mux: halt > siic > rti > redirect > stall > increment.
// Purely combinational; a held PC is the default when nothing advances it.
module pc_next
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] SIIC_VEC = ADDR_W'(SIIC_VEC_DEF)
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_epc,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_halt,
    input  logic              i_siic,
    input  logic              i_rti,
    input  logic              i_redirect,
    input  logic              i_stall,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_pc_nxt
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

    always_comb begin
        o_pc_nxt = i_pc;
        if (i_halt)          o_pc_nxt = i_pc;
        else if (i_siic)     o_pc_nxt = SIIC_VEC;
        else if (i_rti)      o_pc_nxt = i_epc;
        else if (i_redirect) o_pc_nxt = i_redirect_pc;
        else if (i_stall)    o_pc_nxt = i_pc;
        else if (i_advance)  o_pc_nxt = i_pc + PC_STEP;
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, Rd/Done/Stall memory reads, 1-cycle mem_done->instr_valid, NOP fill,
// redirect/SIIC/RTI vectoring, sticky halt. IFETCH_ALIGN_CHK_EN enables odd-target err+halt.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] SIIC_VEC = ADDR_W'(SIIC_VEC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              siic,
    input  logic [ADDR_W-1:0] siic_ret_pc,
    input  logic              rti,
    input  logic              halt_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
    input  logic              mem_done,
    input  logic              mem_stall,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_plus2,
    output logic [ADDR_W-1:0] epc,
    output logic              halt_back,
    output logic              err
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2);

    fetch_state_t      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, r_pc_plus2, r_epc, w_pc_nxt;
    logic [15:0]       r_instr;
    logic              r_instr_valid, r_halt_back;
    logic              w_halted, w_flush, w_go_halt, w_hold, w_issue, w_accept, w_align_err;

    assign w_halted  = (r_state == HALTED);
    assign w_flush   = !w_halted && (siic || rti || redirect);
    assign w_go_halt = !w_halted && (halt_in || w_align_err);
    assign w_hold    = !halt_in && !(siic || rti || redirect) && stall_in &&
                       (((r_state == FETCH) && r_instr_valid) || (r_state == HOLD));
    // A flush or halt cycle never starts a request, so the address only moves between requests.
    assign w_issue   = (r_state == FETCH) && !halt_in && !(siic || rti || redirect) &&
                       !(stall_in && r_instr_valid);
    assign w_accept  = w_issue && mem_done && !mem_stall;

`ifdef IFETCH_ALIGN_CHK_EN
    logic r_err;
    assign w_align_err = !w_halted && !halt_in && !siic &&
                         ((rti && r_epc[0]) || (!rti && redirect && redirect_pc[0]));
    always_ff @(posedge clk) begin
        if (rst)                          r_err <= 1'b0;
        else if (w_go_halt && w_align_err) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign w_align_err = 1'b0;
    assign err         = 1'b0;
`endif

    pc_next #(
        .ADDR_W   (ADDR_W),
        .SIIC_VEC (SIIC_VEC)
    ) u_pc_next (
        .i_pc          (r_pc),
        .i_epc         (r_epc),
        .i_redirect_pc (redirect_pc),
        .i_halt        (w_halted || w_go_halt),
        .i_siic        (siic),
        .i_rti         (rti),
        .i_redirect    (redirect),
        .i_stall       (w_hold),
        .i_advance     (w_accept),
        .o_pc_nxt      (w_pc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_halted)       w_state_nxt = HALTED;
        else if (w_go_halt) w_state_nxt = HALTED;
        else if (w_flush)   w_state_nxt = FETCH;
        else begin
            case (r_state)
                FETCH:   if (stall_in && r_instr_valid) w_state_nxt = HOLD;
                HOLD:    if (!stall_in)                 w_state_nxt = FETCH;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_pc_plus2    <= RESET_PC + PC_STEP;
            r_epc         <= '0;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_halt_back   <= 1'b0;
        end else if (!w_halted) begin
            r_pc <= w_pc_nxt;
            if (w_go_halt) begin
                r_instr       <= NOP_INSTR;
                r_instr_valid <= 1'b0;
                r_halt_back   <= 1'b1;
            end else if (w_flush) begin
                r_instr       <= NOP_INSTR;
                r_instr_valid <= 1'b0;
                if (siic) r_epc <= siic_ret_pc;
            end else if (!w_hold) begin
                // Leaving HOLD: decode consumed the held word in the release cycle.
                r_instr       <= w_accept ? mem_data : NOP_INSTR;
                r_instr_valid <= w_accept;
                if (w_accept) r_pc_plus2 <= r_pc + PC_STEP;
            end
        end
    end

    assign mem_addr    = r_pc;
    assign mem_rd      = w_issue && !rst;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign pc_plus2    = r_pc_plus2;
    assign epc         = r_epc;
    assign halt_back   = r_halt_back;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a per-cycle vector table plus hand-written reset,
// memory-stall, reset-mid-read and alignment sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in, redirect, siic, rti, halt_in;
    logic [15:0] redirect_pc, siic_ret_pc;
    logic [15:0] mem_addr, mem_data;
    logic        mem_rd, mem_done, mem_stall;
    logic [15:0] instr, pc_plus2, epc;
    logic        instr_valid, halt_back, err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .siic        (siic),
        .siic_ret_pc (siic_ret_pc),
        .rti         (rti),
        .halt_in     (halt_in),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_done    (mem_done),
        .mem_stall   (mem_stall),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_plus2    (pc_plus2),
        .epc         (epc),
        .halt_back   (halt_back),
        .err         (err)
    );

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] rpc;
        logic        siic;
        logic [15:0] ret;
        logic        rti;
        logic        halt;
        logic        done;
        logic [15:0] data;
        logic        e_rd;
        logic [15:0] e_addr;
        logic [15:0] e_instr;
        logic        e_vld;
        logic [15:0] e_pp2;
        logic [15:0] e_epc;
        logic        e_hb;
    } vec_t;

    vec_t tbl[28];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        stall_in = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        siic = 1'b0; siic_ret_pc = 16'h0000; rti = 1'b0; halt_in = 1'b0;
        mem_data = 16'h0000; mem_done = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          stall redir rpc       siic  ret       rti   halt  done  data      | rd  addr      instr     vld   pp2       epc       hb
        tbl[0]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0000,16'h0800,1'b0,16'h0002,16'h0000,1'b0};
        tbl[1]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h4000, 1'b1,16'h0000,16'h0800,1'b0,16'h0002,16'h0000,1'b0};
        tbl[2]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,16'h4000,1'b1,16'h0002,16'h0000,1'b0};
        tbl[3]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b1,16'hD800, 1'b1,16'h0002,16'h0800,1'b0,16'h0002,16'h0000,1'b0};
        tbl[4]  = '{1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0004,16'hD800,1'b1,16'h0004,16'h0000,1'b0};
        tbl[5]  = '{1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0004,16'hD800,1'b1,16'h0004,16'h0000,1'b0};
        tbl[6]  = '{1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0004,16'hD800,1'b1,16'h0004,16'h0000,1'b0};
        tbl[7]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0004,16'hD800,1'b1,16'h0004,16'h0000,1'b0};
        tbl[8]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0004,16'h0800,1'b0,16'h0004,16'h0000,1'b0};
        tbl[9]  = '{1'b0,1'b1,16'h0040,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h1234, 1'b0,16'h0004,16'h0800,1'b0,16'h0004,16'h0000,1'b0};
        tbl[10] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0040,16'h0800,1'b0,16'h0004,16'h0000,1'b0};
        tbl[11] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h5555, 1'b1,16'h0040,16'h0800,1'b0,16'h0004,16'h0000,1'b0};
        tbl[12] = '{1'b0,1'b0,16'h0000,1'b1,16'h0012,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0042,16'h5555,1'b1,16'h0042,16'h0000,1'b0};
        tbl[13] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,16'h0800,1'b0,16'h0042,16'h0012,1'b0};
        tbl[14] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,16'h0800,1'b0,16'h0042,16'h0012,1'b0};
        tbl[15] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,16'h0800,1'b0,16'h0042,16'h0012,1'b0};
        tbl[16] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,16'h0800,1'b0,16'h0042,16'h0012,1'b0};
        tbl[17] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0002,16'h0800,1'b0,16'h0042,16'h0012,1'b0};
        tbl[18] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0012,16'h0800,1'b0,16'h0042,16'h0012,1'b0};
        tbl[19] = '{1'b0,1'b0,16'h0000,1'b1,16'h0020,1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0012,16'h0800,1'b0,16'h0042,16'h0012,1'b0};
        tbl[20] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0002,16'h0800,1'b0,16'h0042,16'h0020,1'b0};
        tbl[21] = '{1'b0,1'b1,16'hFFFE,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0002,16'h0800,1'b0,16'h0042,16'h0020,1'b0};
        tbl[22] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h1111, 1'b1,16'hFFFE,16'h0800,1'b0,16'h0042,16'h0020,1'b0};
        tbl[23] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b1,16'h2222, 1'b1,16'h0000,16'h1111,1'b1,16'h0000,16'h0020,1'b0};
        tbl[24] = '{1'b0,1'b1,16'h0080,1'b0,16'h0000,1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0002,16'h2222,1'b1,16'h0002,16'h0020,1'b0};
        tbl[25] = '{1'b0,1'b1,16'h0040,1'b1,16'h0030,1'b1,1'b0,1'b1,16'h3333, 1'b0,16'h0002,16'h0800,1'b0,16'h0002,16'h0020,1'b1};
        tbl[26] = '{1'b1,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0002,16'h0800,1'b0,16'h0002,16'h0020,1'b1};
        tbl[27] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0002,16'h0800,1'b0,16'h0002,16'h0020,1'b1};

        clr();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_mem_rd",   {15'b0, mem_rd},      16'h0000);
        chk("rst_addr",     mem_addr,             16'h0000);
        chk("rst_instr",    instr,                16'h0800);
        chk("rst_valid",    {15'b0, instr_valid}, 16'h0000);
        chk("rst_pc_plus2", pc_plus2,             16'h0002);
        chk("rst_epc",      epc,                  16'h0000);
        chk("rst_halt",     {15'b0, halt_back},   16'h0000);
        chk("rst_err",      {15'b0, err},         16'h0000);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            stall_in = tbl[i].stall; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
            siic = tbl[i].siic; siic_ret_pc = tbl[i].ret; rti = tbl[i].rti;
            halt_in = tbl[i].halt; mem_done = tbl[i].done; mem_data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("r%0d_mem_rd", i),   {15'b0, mem_rd},      {15'b0, tbl[i].e_rd});
            chk($sformatf("r%0d_addr", i),     mem_addr,             tbl[i].e_addr);
            chk($sformatf("r%0d_instr", i),    instr,                tbl[i].e_instr);
            chk($sformatf("r%0d_valid", i),    {15'b0, instr_valid}, {15'b0, tbl[i].e_vld});
            chk($sformatf("r%0d_pc_plus2", i), pc_plus2,             tbl[i].e_pp2);
            chk($sformatf("r%0d_epc", i),      epc,                  tbl[i].e_epc);
            chk($sformatf("r%0d_halt", i),     {15'b0, halt_back},   {15'b0, tbl[i].e_hb});
            cyc();
        end

        // Only reset leaves HALTED.
        clr();
        rst = 1'b1;
        @(negedge clk);
        chk("halt_rst_mem_rd", {15'b0, mem_rd}, 16'h0000);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("post_halt_addr",   mem_addr,           16'h0000);
        chk("post_halt_mem_rd", {15'b0, mem_rd},    16'h0001);
        chk("post_halt_hb",     {15'b0, halt_back}, 16'h0000);
        chk("post_halt_epc",    epc,                16'h0000);

        // mem_done qualified by mem_stall is not a completed read.
        mem_done = 1'b1; mem_stall = 1'b1; mem_data = 16'h7777;
        cyc();
        clr();
        @(negedge clk);
        chk("mstall_instr", instr,            16'h0800);
        chk("mstall_addr",  mem_addr,         16'h0000);
        chk("mstall_rd",    {15'b0, mem_rd},  16'h0001);
        mem_done = 1'b1; mem_data = 16'h7777;
        cyc();
        clr();
        @(negedge clk);
        chk("mstall_done_instr", instr,                16'h7777);
        chk("mstall_done_valid", {15'b0, instr_valid}, 16'h0001);
        chk("mstall_done_addr",  mem_addr,             16'h0002);
        chk("mstall_done_pp2",   pc_plus2,             16'h0002);

        // Reset mid-read: request drops and the late word is ignored.
        rst = 1'b1; mem_done = 1'b1; mem_data = 16'h9999;
        @(negedge clk);
        chk("rstmid_mem_rd", {15'b0, mem_rd}, 16'h0000);
        cyc();
        rst = 1'b0; mem_done = 1'b0;
        @(negedge clk);
        chk("rstmid_instr", instr,                16'h0800);
        chk("rstmid_valid", {15'b0, instr_valid}, 16'h0000);
        chk("rstmid_addr",  mem_addr,             16'h0000);

        // Odd redirect target.
        redirect = 1'b1; redirect_pc = 16'h0021;
        cyc();
        clr();
        @(negedge clk);
`ifdef IFETCH_ALIGN_CHK_EN
        chk("align_err",    {15'b0, err},       16'h0001);
        chk("align_halt",   {15'b0, halt_back}, 16'h0001);
        chk("align_mem_rd", {15'b0, mem_rd},    16'h0000);
`else
        chk("align_err",    {15'b0, err},       16'h0000);
        chk("align_halt",   {15'b0, halt_back}, 16'h0000);
        chk("align_addr",   mem_addr,           16'h0021);
        chk("align_mem_rd", {15'b0, mem_rd},    16'h0001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch-stage producer of the 16-bit instruction word consumed by the decode stage's opcode decoder.
- Holds the PC and issues instruction-memory reads over a Rd/Done/Stall handshake.
- Presents each instruction with a valid bit; NOP is substituted when no valid word is present.
- Applies branch/jump redirects, SIIC/RTI vectoring with an EPC, and sticky halt. Drives halt_back back to decode.

Parameters:
- ADDR_W, 16: PC and memory address width.
- RESET_PC, 16'h0000: PC value loaded on reset.
- SIIC_VEC, 16'h0002: PC target taken on siic.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- stall_in  in  1  decode hazard stall; hold current instruction
- redirect  in  1  taken branch/jump from decode
- redirect_pc  in  ADDR_W  redirect target
- siic  in  1  SIIC decoded this cycle
- siic_ret_pc  in  ADDR_W  PC+2 of the SIIC instruction
- rti  in  1  RTI decoded this cycle
- halt_in  in  1  HALT decoded this cycle
- mem_addr  out  ADDR_W  read address
- mem_rd  out  1  read request
- mem_data  in  16  read data, valid with mem_done
- mem_done  in  1  read complete
- mem_stall  in  1  memory busy; request not accepted
- instr  out  16  instruction to decode (opcode in [15:11])
- instr_valid  out  1  instr holds a real fetched word
- pc_plus2  out  ADDR_W  PC+2 of instr
- epc  out  ADDR_W  saved exception return PC
- halt_back  out  1  sticky halt to decoder
- err  out  1  fetch error; only with the optional feature, else tied 0

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values:
  - pc=RESET_PC, state=FETCH.
  - instr=16'h0800 (NOP, opcode 00001), instr_valid=0.
  - pc_plus2=RESET_PC+2, epc=0, halt_back=0, err=0.
  - mem_rd=0 in the reset cycle.
- States: FETCH, HOLD, HALTED.
- FETCH:
  - mem_rd=1, mem_addr=pc, held stable until mem_done.
  - mem_stall=1 means retry with the same address next cycle.
  - On mem_done: instr<=mem_data, instr_valid<=1, pc_plus2<=pc+2, pc<=pc+2.
  - Without mem_done: instr=NOP, instr_valid=0.
  - Latency is 1 cycle from mem_done to instr_valid.
- FETCH to HOLD: if stall_in=1 while instr_valid=1, go to HOLD.
  - The new fetch is suppressed: mem_rd=0.
  - instr and pc_plus2 are unchanged.
- HOLD: stays while stall_in=1. Returns to FETCH the cycle after stall_in falls.
- Priority per cycle: rst > halt_in > siic > rti > redirect > stall_in > normal fetch.
- Redirect / siic / rti (any state except HALTED):
  - Next PC: redirect gives redirect_pc; siic gives SIIC_VEC; rti gives epc.
  - instr<=NOP, instr_valid<=0, state<=FETCH.
  - An outstanding read is abandoned. A mem_done in that same cycle is discarded.
  - siic also sets epc<=siic_ret_pc.
  - siic and rti together: siic wins, epc is updated.
- halt_in:
  - State goes to HALTED; halt_back<=1, sticky.
  - mem_rd=0, instr=NOP, instr_valid=0.
  - Only rst leaves HALTED. Redirect, siic, rti and stall are ignored there.
- PC arithmetic: modulo 2^ADDR_W, so 16'hFFFE+2 wraps to 16'h0000.
- Reset mid-read: request drops in the reset cycle. A late mem_done is ignored because mem_rd=0.

Optional Feature:
- Macro: IFETCH_ALIGN_CHK_EN.
- With it defined:
  - A redirect or rti target with bit0=1 sets err=1 (sticky) and enters HALTED with halt_back=1.
  - siic is unaffected, since SIIC_VEC is aligned.
- Without it: err is tied 0, and odd targets are fetched as-is.

Decomposition:
- Shared package isa_pkg holds:
  - the 5-bit opcode constants, including HALT, NOP, SIIC, RTI;
  - NOP_INSTR=16'h0800;
  - SIIC_VEC default;
  - the fetch-state encoding (FETCH=2'b00, HOLD=2'b01, HALTED=2'b10).
- One sub-module, pc_next: combinational next-PC priority mux (halt/siic/rti/redirect/stall/increment). It makes the priority order unit-testable.

Test Plan:
- Reset, mem_done on 2nd cycle, mem_data=16'h4000 -> mem_addr=0000; next cycle instr=4000, instr_valid=1, pc_plus2=0002; next mem_addr=0002.
- stall_in=1 for 3 cycles with instr=16'hD800 valid -> mem_rd=0 for 3 cycles, instr stays D800; fetch resumes at same pc after release.
- redirect=1, redirect_pc=16'h0040, mem_done coincident -> returned word dropped, instr_valid=0, next mem_addr=0040.
- siic with siic_ret_pc=16'h0012, then rti 5 cycles later -> epc=0012, fetch 0002, then fetch 0012.
- halt_in=1 plus redirect same cycle -> HALTED, halt_back=1, mem_rd=0 forever; only rst restores mem_addr=0000.
- With IFETCH_ALIGN_CHK_EN, redirect_pc=16'h0021 -> err=1, halt_back=1. Without the macro, next mem_addr=0021.
